// File: rtl/multicycle_main_controller_pkg.sv
// Shared encodings for the multicycle RISC-V main controller: opcodes,
// ALU class codes, datapath mux selects and the controller state enum.
package multicycle_main_controller_pkg;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  typedef enum logic [1:0] {
    ALU_SW_LW = 2'b00,
    ALU_BEQ   = 2'b01,
    ALU_RT    = 2'b10,
    ALU_IT    = 2'b11
  } alu_opc_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_MEMDATA   = 2'b01,
    RES_ALURESULT = 2'b10,
    RES_IMMEXT    = 2'b11
  } result_src_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_REGA  = 2'b10
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SRCB_REGB = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } alu_src_b_e;

  // Encodings are visible on state_dbg; 4'd14 and 4'd15 are unused.
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR1     = 4'd11,
    S_JALR2     = 4'd12,
    S_LUI       = 4'd13
  } state_e;

endpackage

// File: rtl/multicycle_main_controller_branch_cond.sv
// Branch resolution from funct3 and the ALU flags of the compare cycle.
module multicycle_main_controller_branch_cond
  import multicycle_main_controller_pkg::*;
(
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       neg,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (func3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = ~zero;
      F3_BLT:  taken = neg;
      F3_BGE:  taken = ~neg;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_controller.sv
// Main control FSM of the multicycle RISC-V core: sequences each instruction
// and drives datapath enables, mux selects and the ALU_opc class code.
module multicycle_main_controller
  import multicycle_main_controller_pkg::*;
#(
  parameter bit RESET_PC_WRITE_GATE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       neg,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic [1:0] ALU_opc,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_e state_q, state_d;
  logic   is_store_q;
  logic   taken;
  logic   pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw;
  logic   write_gate;

  multicycle_main_controller_branch_cond u_branch_cond (
    .func3 (func3),
    .zero  (zero),
    .neg   (neg),
    .taken (taken)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // op is only sampled in DECODE, so the lw/sw choice is held for MEM_ADR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      is_store_q <= 1'b0;
    else if (state_q == S_DECODE)  is_store_q <= (op == OP_SW);
  end

  always_comb begin
    state_d       = S_FETCH;
    pc_write_raw  = 1'b0;
    AdrSrc        = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_REGB;
    ImmSrc        = IMM_I;
    reg_write_raw = 1'b0;
    ALU_opc       = ALU_SW_LW;
    illegal_raw   = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
        ALUSrcB      = SRCB_FOUR;
        ResultSrc    = RES_ALURESULT;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        if (op == OP_B)        ImmSrc = IMM_B;
        else if (op == OP_JAL) ImmSrc = IMM_J;
        case (op)
          OP_LW, OP_SW: state_d = S_MEM_ADR;
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_B:         state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          OP_JALR:      state_d = S_JALR1;
          OP_LUI:       state_d = S_LUI;
          default: begin
            state_d     = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      S_MEM_ADR: begin
        ALUSrcA = SRCA_REGA;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = is_store_q ? IMM_S : IMM_I;
        state_d = is_store_q ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        AdrSrc  = 1'b1;
        state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        ResultSrc     = RES_MEMDATA;
        reg_write_raw = 1'b1;
      end
      S_MEM_WRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = SRCA_REGA;
        ALU_opc = ALU_RT;
        state_d = S_ALU_WB;
      end
      S_EXEC_I: begin
        ALUSrcA = SRCA_REGA;
        ALUSrcB = SRCB_IMM;
        ALU_opc = ALU_IT;
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_raw = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA      = SRCA_REGA;
        ALU_opc      = ALU_BEQ;
        pc_write_raw = taken;
      end
      S_JAL: begin
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_FOUR;
        pc_write_raw = 1'b1;
        state_d      = S_ALU_WB;
      end
      S_JALR1: begin
        ALUSrcA = SRCA_REGA;
        ALUSrcB = SRCB_IMM;
        state_d = S_JALR2;
      end
      S_JALR2: begin
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_FOUR;
        pc_write_raw = 1'b1;
        state_d      = S_ALU_WB;
      end
      S_LUI: begin
        ImmSrc        = IMM_U;
        ResultSrc     = RES_IMMEXT;
        reg_write_raw = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset parks the FSM in FETCH, whose enables must not leak while rst is low.
  assign write_gate = RESET_PC_WRITE_GATE && !rst;

  assign PCWrite    = pc_write_raw  & ~write_gate;
  assign IRWrite    = ir_write_raw  & ~write_gate;
  assign MemWrite   = mem_write_raw & ~write_gate;
  assign RegWrite   = reg_write_raw & ~write_gate;
  assign illegal_op = illegal_raw   & rst;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Self-checking bench: directed and random instruction streams compared
// cycle by cycle against a per-instruction state-sequence model.
module tb_multicycle_main_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] op = 7'b0110011;
  logic [2:0] func3 = '0;
  logic       zero = 1'b0;
  logic       neg = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALU_opc;
  logic [2:0] ImmSrc;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;

  localparam int FETCH = 0, DECODE = 1, MEM_ADR = 2, MEM_READ = 3, MEM_WB = 4,
                 MEM_WRITE = 5, EXEC_R = 6, EXEC_I = 7, ALU_WB = 8, BRANCH = 9,
                 JAL = 10, JALR1 = 11, JALR2 = 12, LUI = 13;

  multicycle_main_controller #(.RESET_PC_WRITE_GATE(1'b1)) dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .zero(zero), .neg(neg),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .RegWrite(RegWrite), .ALU_opc(ALU_opc), .illegal_op(illegal_op),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  wire [20:0] obs = {state_dbg, illegal_op, ALU_opc, RegWrite, ImmSrc, ALUSrcB,
                     ALUSrcA, ResultSrc, IRWrite, MemWrite, AdrSrc, PCWrite};

  int seq [8];

  // Ordered list of states an instruction visits, starting at FETCH.
  function automatic int plan(input logic [6:0] o);
    seq[0] = FETCH;
    seq[1] = DECODE;
    case (o)
      7'b0000011: begin seq[2] = MEM_ADR; seq[3] = MEM_READ; seq[4] = MEM_WB; return 5; end
      7'b0100011: begin seq[2] = MEM_ADR; seq[3] = MEM_WRITE; return 4; end
      7'b0110011: begin seq[2] = EXEC_R; seq[3] = ALU_WB; return 4; end
      7'b0010011: begin seq[2] = EXEC_I; seq[3] = ALU_WB; return 4; end
      7'b1100011: begin seq[2] = BRANCH; return 3; end
      7'b1101111: begin seq[2] = JAL; seq[3] = ALU_WB; return 4; end
      7'b1100111: begin seq[2] = JALR1; seq[3] = JALR2; seq[4] = ALU_WB; return 5; end
      7'b0110111: begin seq[2] = LUI; return 3; end
      default: return 2;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic n);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n;
      3'b101:  return !n;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [20:0] expect_out(input int s, input logic [6:0] o,
                                             input logic [2:0] f3, input logic z,
                                             input logic n);
    logic pcw = 0, adr = 0, memw = 0, irw = 0, regw = 0, ill = 0;
    logic [1:0] res = 0, sa = 0, sb = 0, alu = 0;
    logic [2:0] imm = 0;
    logic [3:0] st;
    st = s[3:0];
    case (s)
      FETCH:     begin irw = 1; pcw = 1; sb = 2'b10; res = 2'b10; end
      DECODE: begin
        sa = 2'b01; sb = 2'b01;
        imm = (o == 7'b1100011) ? 3'b010 : (o == 7'b1101111) ? 3'b011 : 3'b000;
        ill = (plan(o) == 2);
      end
      MEM_ADR:   begin sa = 2'b10; sb = 2'b01; imm = (o == 7'b0100011) ? 3'b001 : 3'b000; end
      MEM_READ:  adr = 1;
      MEM_WB:    begin res = 2'b01; regw = 1; end
      MEM_WRITE: begin adr = 1; memw = 1; end
      EXEC_R:    begin sa = 2'b10; alu = 2'b10; end
      EXEC_I:    begin sa = 2'b10; sb = 2'b01; alu = 2'b11; end
      ALU_WB:    regw = 1;
      BRANCH:    begin sa = 2'b10; alu = 2'b01; pcw = branch_taken(f3, z, n); end
      JAL:       begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      JALR1:     begin sa = 2'b10; sb = 2'b01; end
      JALR2:     begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      LUI:       begin imm = 3'b100; res = 2'b11; regw = 1; end
      default:   ;
    endcase
    return {st, ill, alu, regw, imm, sb, sa, res, irw, memw, adr, pcw};
  endfunction

  // FETCH selects with every write enable held low.
  function automatic logic [20:0] reset_out();
    logic [20:0] v;
    v = expect_out(FETCH, 7'b0, 3'b0, 1'b0, 1'b0);
    v[0] = 1'b0;
    v[3] = 1'b0;
    return v;
  endfunction

  task automatic check(input string tag, input logic [20:0] got, input logic [20:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Runs one instruction from FETCH; abort_at (if reached) pulls rst low in that cycle.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic z,
                           input logic n, input int abort_at);
    int len;
    string tag;
    len = plan(o);
    for (int i = 0; i < len; i++) begin
      op    = (seq[i] == DECODE) ? o : 7'($urandom);
      func3 = (seq[i] == BRANCH) ? f3 : 3'($urandom);
      zero  = (seq[i] == BRANCH) ? z : 1'($urandom);
      neg   = (seq[i] == BRANCH) ? n : 1'($urandom);
      if (i == abort_at) begin
        rst = 1'b0;
        #1 check("abort_reset", obs, reset_out());
        for (int k = 0; k < 2; k++) begin
          @(posedge clk);
          #1 check("abort_hold", obs, reset_out());
        end
        rst = 1'b1;
        #1 check("abort_release", obs, expect_out(FETCH, o, f3, z, n));
        return;
      end
      tag = $sformatf("op%b_step%0d", o, i);
      #1 check(tag, obs, expect_out(seq[i], o, f3, z, n));
      @(posedge clk);
      #1;
    end
  endtask

  logic [6:0] op_tbl [9];

  initial begin
    op_tbl = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
               7'b1101111, 7'b1100111, 7'b0110111, 7'b1111111};
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 check("reset_hold", obs, reset_out());
    end
    rst = 1'b1;

    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, -1);
    run_instr(7'b0000011, 3'b000, 1'b0, 1'b0, -1);
    run_instr(7'b0100011, 3'b000, 1'b0, 1'b0, -1);
    run_instr(7'b1100011, 3'b000, 1'b1, 1'b0, -1);
    run_instr(7'b1100011, 3'b001, 1'b1, 1'b0, -1);
    run_instr(7'b1100011, 3'b100, 1'b0, 1'b1, -1);
    run_instr(7'b1100011, 3'b101, 1'b0, 1'b1, -1);
    run_instr(7'b1100011, 3'b010, 1'b1, 1'b1, -1);
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, -1);
    run_instr(7'b1100111, 3'b000, 1'b0, 1'b0, -1);
    run_instr(7'b0110111, 3'b000, 1'b0, 1'b0, -1);
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, -1);
    run_instr(7'b0010011, 3'b000, 1'b0, 1'b0, -1);
    run_instr(7'b0000011, 3'b000, 1'b0, 1'b0, 3);
    run_instr(7'b0000011, 3'b000, 1'b0, 1'b0, -1);

    for (int t = 0; t < 300; t++) begin
      logic [6:0] o;
      int sel;
      sel = $urandom_range(0, 9);
      o = (sel == 9) ? 7'($urandom) : op_tbl[sel];
      run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
